// File: rtl/mc_b_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_b_reader_if : write port and unload handshake of mc_b_reader    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface mc_b_reader_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) ();
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             WEB;
   logic [AW-1:0]    AddrB;
   logic [WIDTH-1:0] DataInB;
   logic             Start;
   logic             DOutReady;
   logic [WIDTH-1:0] DOut;
   logic [AW-1:0]    AddrOut;
   logic             DOutValid;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Sum;

   modport slave (
      input  WEB, AddrB, DataInB, Start, DOutReady,
      output DOut, AddrOut, DOutValid, Busy, Done, Sum
   );

   modport master (
      output WEB, AddrB, DataInB, Start, DOutReady,
      input  DOut, AddrOut, DOutValid, Busy, Done, Sum
   );
endinterface
`default_nettype wire

// File: rtl/mc_b_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mc_b_reader : result buffer unloaded word-by-word with a checksum  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mc_b_reader #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic      clock,
   input  wire logic      Reset,
   mc_b_reader_if.slave   bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_dout;
   logic [AW-1:0]    r_addr_out;
   logic [WIDTH-1:0] r_sum;
   logic             w_busy;
   logic             w_done;
   logic             w_valid;
   logic             w_last;
   logic             w_handshake;
   logic [WIDTH-1:0] w_acc_next;

   assign w_last      = (r_rd_ptr == c_LAST);
   assign w_handshake = w_valid & bus.DOutReady;
   assign w_acc_next  = r_acc + r_dout;

   always_ff @(posedge clock) begin
      if (Reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b1;
      w_done       = 1'b0;
      w_valid      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (bus.Start) begin
               w_next_state = ST_READ;
            end
         end
         ST_READ: begin
            w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            w_valid = 1'b1;
            if (bus.DOutReady) begin
               w_next_state = w_last ? ST_DONE : ST_READ;
            end
         end
         ST_DONE: begin
            w_done       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // The read in ST_READ samples the array before a same-edge write lands.
   always_ff @(posedge clock) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rd_ptr   <= '0;
         r_acc      <= '0;
         r_dout     <= '0;
         r_addr_out <= '0;
         r_sum      <= '0;
      end else begin
         if (bus.WEB) begin
            r_mem[bus.AddrB] <= bus.DataInB;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.Start) begin
                  r_rd_ptr <= '0;
                  r_acc    <= '0;
               end
            end
            ST_READ: begin
               r_dout     <= r_mem[r_rd_ptr];
               r_addr_out <= r_rd_ptr;
            end
            ST_HOLD: begin
               if (w_handshake) begin
                  r_acc <= w_acc_next;
                  if (w_last) begin
                     r_sum <= w_acc_next;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + AW'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.DOut      = r_dout;
   assign bus.AddrOut   = r_addr_out;
   assign bus.DOutValid = w_valid;
   assign bus.Busy      = w_busy;
   assign bus.Done      = w_done;
   assign bus.Sum       = r_sum;
endmodule
`default_nettype wire

// File: tb/tb_mc_b_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mc_b_reader : scoreboard bench for mc_b_reader                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mc_b_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mc_b_reader_if #(.WIDTH(8), .DEPTH(4)) bus ();

   mc_b_reader #(.WIDTH(8), .DEPTH(4)) dut (
      .clock (clk),
      .Reset (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic [7:0] d;
      logic [1:0] a;
   } exp_t;

   exp_t       q[$];
   logic [7:0] model_mem [4];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus.WEB     = 1'b1;
      bus.AddrB   = a;
      bus.DataInB = d;
      model_mem[a] = d;
      tick;
      bus.WEB = 1'b0;
   endtask

   task automatic write_all(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
      wr(2'd0, d0);
      wr(2'd1, d1);
      wr(2'd2, d2);
      wr(2'd3, d3);
   endtask

   // One complete unload; expected words are snapshotted from the model at Start.
   task automatic do_unload(input string tag, input int stall_len, input int wr_c,
                            input logic [1:0] wr_a, input logic [7:0] wr_d,
                            input bit extra_st);
      logic [7:0] exp_sum;
      exp_t       e;
      int         s, words, dones, done_at, stall_left, stalls, post;
      exp_sum = 8'h00;
      for (int i = 0; i < 4; i++) begin
         q.push_back({model_mem[i], 2'(i)});
         exp_sum = exp_sum + model_mem[i];
      end
      bus.Start = 1'b1;
      bus.DOutReady = 1'b1;
      s = cyc; words = 0; dones = 0; done_at = -1; stall_left = stall_len; stalls = 0; post = 0;
      for (int c = 0; c < 80; c++) begin
         tick;
         bus.Start = extra_st && (c == 3 || bus.Done === 1'b1);
         bus.WEB   = (c == wr_c);
         if (c == wr_c) begin
            bus.AddrB   = wr_a;
            bus.DataInB = wr_d;
            model_mem[wr_a] = wr_d;
         end
         if (bus.DOutValid === 1'b1 && bus.AddrOut === 2'd2 && stall_left > 0) begin
            bus.DOutReady = 1'b0;
            stall_left--;
         end else begin
            bus.DOutReady = 1'b1;
         end
         @(negedge clk);
         if (bus.DOutValid === 1'b1 && bus.DOutReady === 1'b0) begin
            n_vec++; stalls++;
            if (q.size() == 0 || bus.DOut !== q[0].d || bus.AddrOut !== q[0].a) begin
               n_err++;
               $display("FAIL %s stall_hold: DOut=%h AddrOut=%0d required %h/%0d", tag,
                        bus.DOut, bus.AddrOut, (q.size() > 0) ? q[0].d : 8'hxx,
                        (q.size() > 0) ? q[0].a : 2'bxx);
            end
         end
         if (bus.DOutValid === 1'b1 && bus.DOutReady === 1'b1) begin
            n_vec++; words++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL %s extra_word: DOut=%h AddrOut=%0d required none", tag,
                        bus.DOut, bus.AddrOut);
            end else begin
               e = q.pop_front();
               if (bus.DOut !== e.d || bus.AddrOut !== e.a) begin
                  n_err++;
                  $display("FAIL %s word: DOut=%h AddrOut=%0d required %h/%0d", tag,
                           bus.DOut, bus.AddrOut, e.d, e.a);
               end
            end
         end
         if (bus.Done === 1'b1) begin
            dones++; n_vec++;
            if (done_at < 0) done_at = cyc - s;
            if (bus.Sum !== exp_sum) begin
               n_err++;
               $display("FAIL %s sum_at_done: Sum=%h required %h", tag, bus.Sum, exp_sum);
            end
         end
         if (dones > 0) post++;
         if (post >= 4) break;
      end
      bus.Start = 1'b0;
      bus.WEB   = 1'b0;
      n_vec++;
      if (words != 4 || dones != 1 || q.size() != 0) begin
         n_err++;
         $display("FAIL %s counts: words=%0d dones=%0d left=%0d required 4/1/0", tag,
                  words, dones, q.size());
      end
      n_vec++;
      if (stalls != stall_len) begin
         n_err++;
         $display("FAIL %s stall_cycles: got %0d required %0d", tag, stalls, stall_len);
      end
      if (stall_len == 0) begin
         n_vec++;
         if (done_at != 9) begin
            n_err++;
            $display("FAIL %s latency: Done after %0d cycles required 9", tag, done_at);
         end
      end
      n_vec++;
      if (bus.Sum !== exp_sum || bus.Busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s after: Sum=%h Busy=%b required %h/0", tag, bus.Sum, bus.Busy, exp_sum);
      end
      q.delete();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.WEB = 1'b1; bus.AddrB = 2'd1; bus.DataInB = 8'hFF;
      bus.Start = 1'b1; bus.DOutReady = 1'b1;
      tick; tick;
      n_vec++;
      if ({bus.DOut, bus.AddrOut, bus.DOutValid, bus.Busy, bus.Done, bus.Sum} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_held: DOut=%h AddrOut=%0d V=%b Busy=%b Done=%b Sum=%h required all 0",
                  bus.DOut, bus.AddrOut, bus.DOutValid, bus.Busy, bus.Done, bus.Sum);
      end
      rst = 1'b0; bus.WEB = 1'b0; bus.Start = 1'b0;
      tick;
      n_vec++;
      if ({bus.DOut, bus.AddrOut, bus.DOutValid, bus.Busy, bus.Done, bus.Sum} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_idle: DOut=%h AddrOut=%0d V=%b Busy=%b Done=%b Sum=%h required all 0",
                  bus.DOut, bus.AddrOut, bus.DOutValid, bus.Busy, bus.Done, bus.Sum);
      end
      for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
      do_unload("reset_zero", 0, -1, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic test_basic;
      write_all(8'h11, 8'h22, 8'h33, 8'hF0);
      do_unload("basic", 0, -1, 2'd0, 8'h00, 1'b0);
      n_vec++;
      if (bus.Sum !== 8'h56) begin
         n_err++;
         $display("FAIL basic_sum_const: Sum=%h required 56", bus.Sum);
      end
   endtask

   task automatic test_back_to_back;
      do_unload("restart_ignored", 0, -1, 2'd0, 8'h00, 1'b1);
   endtask

   task automatic test_rbw;
      do_unload("rbw", 0, 2, 2'd1, 8'hAA, 1'b0);
      do_unload("rbw_after", 0, -1, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic test_stall;
      write_all(8'h11, 8'h22, 8'h33, 8'hF0);
      do_unload("stall", 3, 6, 2'd2, 8'h99, 1'b0);
      do_unload("stall_after", 0, -1, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid;
      bit found;
      write_all(8'h11, 8'h22, 8'h33, 8'hF0);
      bus.Start = 1'b1; bus.DOutReady = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         tick;
         bus.Start = 1'b0;
         if (bus.DOutValid === 1'b1 && bus.AddrOut === 2'd2) begin
            found = 1'b1;
            bus.DOutReady = 1'b0;
         end else begin
            bus.DOutReady = 1'b1;
         end
      end
      n_vec++;
      if (!found) begin
         n_err++;
         $display("FAIL reset_mid_reach: word 2 never held, required held");
      end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      bus.DOutReady = 1'b1;
      n_vec++;
      if (bus.Busy !== 1'b0 || bus.DOutValid !== 1'b0 || bus.Done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_abort: Busy=%b V=%b Done=%b required 0/0/0",
                  bus.Busy, bus.DOutValid, bus.Done);
      end
      for (int c = 0; c < 4; c++) begin
         tick;
         n_vec++;
         if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: Done=%b Busy=%b required 0/0", bus.Done, bus.Busy);
         end
      end
      for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
      q.delete();
      do_unload("reset_mid_zero", 0, -1, 2'd0, 8'h00, 1'b0);
   endtask

   initial begin
      bus.WEB = 1'b0; bus.AddrB = 2'd0; bus.DataInB = 8'h00;
      bus.Start = 1'b0; bus.DOutReady = 1'b0;
      for (int i = 0; i < 4; i++) model_mem[i] = 8'h00;
      test_reset;
      test_basic;
      test_back_to_back;
      test_rbw;
      test_stall;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/mc_b_reader.md
MC_B_READER -- requirements
Module: mc_b_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of result-buffer entries; address width is log2(DEPTH), which is 2 at default.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port WEB, input, 1, write enable for the result buffer.
REQ-006 SHALL have port AddrB, input, 2, write address.
REQ-007 SHALL have port DataInB, input, 8, write data.
REQ-008 SHALL have port Start, input, 1, request to unload the whole buffer.
REQ-009 SHALL have port DOutReady, input, 1, consumer ready to take DOut.
REQ-010 SHALL have port DOut, output, 8, unloaded data word.
REQ-011 SHALL have port AddrOut, output, 2, buffer address of the word on DOut.
REQ-012 SHALL have port DOutValid, output, 1, DOut and AddrOut are valid.
REQ-013 SHALL have port Busy, output, 1, unload in progress.
REQ-014 SHALL have port Done, output, 1, one-cycle pulse marking the end of an unload.
REQ-015 SHALL have port Sum, output, 8, modulo-256 sum of the words sent in the last unload.

Function
REQ-016 SHALL store a DEPTH x WIDTH buffer; when WEB=1 and Reset=0, DataInB is written to AddrB at the clock edge, regardless of FSM state.
REQ-017 SHALL implement the FSM states IDLE, READ, HOLD and DONE.
REQ-018 IDLE: Busy=0 and DOutValid=0; Start=1 -> READ with rd_ptr=0 and the sum accumulator cleared.
REQ-019 READ: registered read of buffer[rd_ptr]; next cycle -> HOLD with DOut=buffer[rd_ptr], AddrOut=rd_ptr and DOutValid=1 (1-cycle read latency).
REQ-020 HOLD: DOut, AddrOut and DOutValid SHALL hold stable until a handshake, defined as DOutValid=1 and DOutReady=1 at the same clock edge.
REQ-021 On a handshake, DOut SHALL be added to the accumulator mod 256; if rd_ptr=DEPTH-1 -> DONE, else rd_ptr+1 -> READ.
REQ-022 DONE: Done=1 for exactly one cycle, Sum is updated to the final accumulator value, DOutValid=0, then -> IDLE.
REQ-023 Busy SHALL be 1 in READ, HOLD and DONE.
REQ-024 Sum SHALL hold its value between unloads.
REQ-025 Throughput SHALL be at most one word per 2 cycles; an unload of 4 words with DOutReady tied to 1 SHALL take 9 cycles from Start to Done.
REQ-026 Start while Busy=1 SHALL be ignored.
REQ-027 Start in the same cycle as Done SHALL be ignored.
REQ-028 A write to buffer[rd_ptr] in the same cycle as its READ SHALL return the old data (read-before-write).
REQ-029 A write during HOLD to the address being held SHALL NOT change DOut.
REQ-030 rd_ptr SHALL NOT wrap past DEPTH-1 within one unload.
REQ-031 DOutReady=1 with DOutValid=0 SHALL have no effect.

Reset
REQ-032 While Reset=1 at a clock edge, the block SHALL clear all buffer entries to 0, go to IDLE, and drive DOut=0, AddrOut=0, DOutValid=0, Busy=0, Done=0, Sum=0, with rd_ptr=0 and the accumulator at 0.
REQ-033 While Reset=1, WEB and Start SHALL be ignored.
REQ-034 Reset asserted mid-unload SHALL abort the unload without any Done pulse.

Verification
REQ-035 Reset for 2 cycles, then idle -> all outputs 0; a subsequent unload returns 0,0,0,0 with Sum=0.
REQ-036 Write 8'h11, 8'h22, 8'h33, 8'hF0 to addresses 0-3, Start with DOutReady=1 -> words 11,22,33,F0 on AddrOut 0-3, Done 9 cycles after Start, Sum=8'h56.
REQ-037 Same data with DOutReady held low 3 cycles on word 2 -> DOut=8'h33 and AddrOut=2 stay stable for the whole stall, then the unload continues normally.
REQ-038 Start pulsed again during Busy, and in the Done cycle -> no restart; exactly 4 words and a single Done pulse.
REQ-039 Write 8'hAA to address 1 in the same cycle as the READ of address 1 (old value 8'h22) -> DOut=8'h22; a following unload returns 8'hAA at address 1.
REQ-040 Reset asserted while word 2 is held -> next cycle Busy=0, DOutValid=0, no Done; a following unload returns all zeros.
